// File: rtl/lsu_byte_lane_aligner.sv
// rtl/lsu_byte_lane_aligner.sv - load/store byte-lane aligner between core memory stage and word bus
// Generates byte enables, lane-shifts store data, splits word-crossing accesses, extends load data.
module lsu_byte_lane_aligner #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN/8-1:0] bus_be,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_split
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int EW   = 2 * NB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_ERR,
    S_RESP
  } state_t;

  // On a 32-bit bus the dword encoding degrades to a plain word access.
  function automatic logic [1:0] eff_size(input logic [1:0] size);
    if (XLEN == 32 && size == 2'b11) return 2'b10;
    return size;
  endfunction

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << eff_size(size);
  endfunction

  function automatic logic [EW-1:0] lane_mask(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [EW-1:0] base;
    case (eff_size(size))
      2'b00:   base = EW'(8'h01);
      2'b01:   base = EW'(8'h03);
      2'b10:   base = EW'(8'h0F);
      default: base = EW'(8'hFF);
    endcase
    return base << off;
  endfunction

  function automatic logic crosses(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [EW-1:0] m;
    m = lane_mask(size, off);
    return |m[EW-1:NB];
  endfunction

  state_t            state;
  logic              r_we;
  logic              r_unsigned;
  logic              r_split;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata0;

  logic              req_split;
  logic [OFFW-1:0]   off;
  logic [EW-1:0]     ext_be;
  logic [XLEN-1:0]   wd_masked;
  logic [2*XLEN-1:0] ext_wd;
  logic [ADDR_W-1:0] beat0_addr;
  logic [ADDR_W-1:0] beat1_addr;
  logic [2*XLEN-1:0] raw;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ld_data;

  assign req_split  = crosses(req_size, req_addr[OFFW-1:0]);
  assign off        = r_addr[OFFW-1:0];
  assign ext_be     = lane_mask(r_size, off);
  assign ext_wd     = {{XLEN{1'b0}}, wd_masked} << {off, 3'b000};
  assign beat0_addr = {r_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign beat1_addr = beat0_addr + ADDR_W'(NB);

  always_comb begin
    int nb;
    wd_masked = '0;
    nb = size_bytes(r_size);
    for (int i = 0; i < NB; i++) begin
      if (i < nb) wd_masked[8*i +: 8] = r_wdata[8*i +: 8];
    end
  end

  // Beat1 data is live on the bus in the same cycle as its bus_ready; beat0 comes from the capture reg.
  assign raw     = r_split ? {bus_rdata, r_rdata0} : {{XLEN{1'b0}}, bus_rdata};
  assign shifted = XLEN'(raw >> {off, 3'b000});

  always_comb begin
    int   nb;
    logic sign;
    logic fill;
    ld_data = '0;
    sign    = 1'b0;
    nb      = size_bytes(r_size);
    for (int i = 0; i < NB; i++) begin
      if (i == nb - 1) sign = shifted[8*i+7];
    end
    fill = sign & ~r_unsigned & (nb != NB);
    for (int i = 0; i < NB; i++) begin
      ld_data[8*i +: 8] = (i < nb) ? shifted[8*i +: 8] : {8{fill}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_split    <= 1'b0;
      r_addr     <= '0;
      r_size     <= '0;
      r_wdata    <= '0;
      r_rdata0   <= '0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      rsp_split  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_wdata    <= req_wdata;
            r_split    <= req_split;
            req_ready  <= 1'b0;
            state      <= (req_split && !ALLOW_MISALIGNED) ? S_ERR : S_BEAT0;
          end
        end
        S_BEAT0: begin
          // First cycle in BEAT0 loads the bus registers from the captured request.
          if (!bus_valid) begin
            bus_valid <= 1'b1;
            bus_we    <= r_we;
            bus_addr  <= beat0_addr;
            bus_be    <= ext_be[NB-1:0];
            bus_wdata <= ext_wd[XLEN-1:0];
          end else if (bus_ready) begin
            r_rdata0 <= bus_rdata;
            if (r_split) begin
              bus_addr  <= beat1_addr;
              bus_be    <= ext_be[EW-1:NB];
              bus_wdata <= ext_wd[2*XLEN-1:XLEN];
              state     <= S_BEAT1;
            end else begin
              bus_valid <= 1'b0;
              bus_we    <= 1'b0;
              bus_addr  <= '0;
              bus_be    <= '0;
              bus_wdata <= '0;
              rsp_valid <= 1'b1;
              rsp_rdata <= r_we ? '0 : ld_data;
              rsp_split <= 1'b0;
              state     <= S_RESP;
            end
          end
        end
        S_BEAT1: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= r_we ? '0 : ld_data;
            rsp_split <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_ERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
          rsp_split <= 1'b0;
          state     <= S_RESP;
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          rsp_split <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          bus_valid <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_lane_aligner.sv
// tb/tb_lsu_byte_lane_aligner.sv - self-checking bench for lsu_byte_lane_aligner (XLEN=32)
// Byte-level reference model; second instance with misaligned splitting disabled.
module tb_lsu_byte_lane_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid_nm, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  logic        req_ready, bus_valid, bus_we, rsp_valid, rsp_err, rsp_split;
  logic [31:0] bus_addr, bus_wdata, rsp_rdata;
  logic [3:0]  bus_be;

  logic        req_ready_nm, bus_valid_nm, bus_we_nm, rsp_valid_nm, rsp_err_nm, rsp_split_nm;
  logic [31:0] bus_addr_nm, bus_wdata_nm, rsp_rdata_nm;
  logic [3:0]  bus_be_nm;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_byte_lane_aligner #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_split(rsp_split)
  );

  lsu_byte_lane_aligner #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_nm), .req_ready(req_ready_nm), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .bus_valid(bus_valid_nm), .bus_ready(bus_ready), .bus_we(bus_we_nm), .bus_addr(bus_addr_nm),
    .bus_be(bus_be_nm), .bus_wdata(bus_wdata_nm), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid_nm), .rsp_rdata(rsp_rdata_nm), .rsp_err(rsp_err_nm), .rsp_split(rsp_split_nm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One access on the main instance with w0/w1 bus wait states on beat0/beat1.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] wdata,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input int w0, input int w1, output logic [31:0] got);
    int          nbytes, off, nbeats, exp_lat, cyc, beat, waited, idx, b, l;
    bit          done, split;
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];
    logic [31:0] eaddr [2];
    logic [31:0] rd [2];
    logic [31:0] val;

    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off    = int'(addr[1:0]);
    rd[0]  = rd0;
    rd[1]  = rd1;
    for (int j = 0; j < 2; j++) begin
      ebe[j] = 4'h0;
      ewd[j] = 32'h0;
    end
    val = 32'h0;
    for (int k = 0; k < nbytes; k++) begin
      idx = off + k;
      b   = idx / 4;
      l   = idx % 4;
      ebe[b][l]        = 1'b1;
      ewd[b][8*l +: 8] = wdata[8*k +: 8];
      val[8*k +: 8]    = rd[b][8*l +: 8];
    end
    if (!uns && nbytes < 4 && val[8*nbytes-1]) begin
      for (int k = nbytes; k < 4; k++) val[8*k +: 8] = 8'hFF;
    end
    if (we) val = 32'h0;
    split    = (off + nbytes) > 4;
    nbeats   = split ? 2 : 1;
    exp_lat  = 3 + (split ? 1 + w1 : 0) + w0;
    eaddr[0] = {addr[31:2], 2'b00};
    eaddr[1] = eaddr[0] + 32'd4;
    got      = 32'h0;

    @(negedge clk);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom);

    cyc = 0; beat = 0; waited = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus_ready = 1'b0;
      bus_rdata = $urandom;
      if (rsp_valid) begin
        done = 1'b1;
        chk("latency", cyc, exp_lat);
        chk("beat_count", beat, nbeats);
        chk("rsp_rdata", rsp_rdata, val);
        chk("rsp_split", {31'h0, rsp_split}, {31'h0, split});
        chk("rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("req_ready_resp", {31'h0, req_ready}, 32'h0);
        chk("bus_valid_resp", {31'h0, bus_valid}, 32'h0);
        got = rsp_rdata;
      end else if (bus_valid) begin
        if (beat >= nbeats) begin
          chk("extra_beat", beat, nbeats - 1);
          done = 1'b1;
        end else begin
          chk($sformatf("bus_addr_b%0d", beat), bus_addr, eaddr[beat]);
          chk($sformatf("bus_be_b%0d", beat), {28'h0, bus_be}, {28'h0, ebe[beat]});
          chk($sformatf("bus_we_b%0d", beat), {31'h0, bus_we}, {31'h0, we});
          if (we) chk($sformatf("bus_wdata_b%0d", beat), bus_wdata, ewd[beat]);
          if (waited < ((beat == 0) ? w0 : w1)) begin
            waited++;
          end else begin
            bus_ready = 1'b1;
            bus_rdata = rd[beat];
            beat++;
            waited = 0;
          end
        end
      end
    end
    if (!done) chk("rsp_timeout", 32'h0, 32'h1);
    @(negedge clk);
    bus_ready = 1'b0;
    chk("rsp_pulse_end", {31'h0, rsp_valid}, 32'h0);
    chk("req_ready_after", {31'h0, req_ready}, 32'h1);
  endtask

  // Boundary-crossing access on the no-split instance: must error without bus traffic.
  task automatic run_err(input logic [31:0] addr, input logic [1:0] size);
    int cyc;
    bit done;
    @(negedge clk);
    req_we = 1'b0; req_addr = addr; req_size = size; req_unsigned = 1'b0;
    req_valid_nm = 1'b1;
    chk("nm_req_ready", {31'h0, req_ready_nm}, 32'h1);
    @(posedge clk);
    #1;
    req_valid_nm = 1'b0;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 10) begin
      @(negedge clk);
      cyc++;
      chk("nm_bus_valid", {31'h0, bus_valid_nm}, 32'h0);
      if (rsp_valid_nm) begin
        done = 1'b1;
        chk("nm_latency", cyc, 2);
        chk("nm_rsp_err", {31'h0, rsp_err_nm}, 32'h1);
      end
    end
    if (!done) chk("nm_rsp_timeout", 32'h0, 32'h1);
    @(negedge clk);
    chk("nm_err_pulse_end", {31'h0, rsp_err_nm}, 32'h0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] ra;
    int          cyc;

    rst_n = 1'b0; req_valid = 1'b0; req_valid_nm = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = '0; req_unsigned = 1'b0; req_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;

    // SB offset 2, then SW straddling 0x1004, then LH straddling a word (signed and unsigned)
    run_access(1'b1, 32'h0000_2002, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 32'h0, 0, 0, got);
    run_access(1'b1, 32'h0000_1002, 2'd2, 1'b0, 32'h1122_3344, 32'h0, 32'h0, 0, 0, got);
    run_access(1'b0, 32'h0000_0003, 2'd1, 1'b0, 32'h0, 32'h8012_3456, 32'h9876_54F0, 0, 0, got);
    chk("lh_signed", got, 32'hFFFF_F080);
    run_access(1'b0, 32'h0000_0003, 2'd1, 1'b1, 32'h0, 32'h8012_3456, 32'h9876_54F0, 0, 0, got);
    chk("lhu_unsigned", got, 32'h0000_F080);

    run_err(32'h0000_0001, 2'd2);
    run_err(32'h0000_0013, 2'd1);

    // Wait states on beat0 of an aligned store, then on both beats of a split load
    run_access(1'b1, 32'h0000_4000, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0, 3, 0, got);
    run_access(1'b0, 32'h0000_4006, 2'd2, 1'b0, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 2, 1, got);
    chk("lw_split_data", got, 32'h3344_AABB);
    // beat1 address wraps to 0
    run_access(1'b1, 32'hFFFF_FFFE, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 0, got);

    for (int i = 0; i < 40; i++) begin
      ra = (i % 5 == 0) ? (32'hFFFF_FFFC + ($urandom % 4)) : $urandom;
      run_access(1'($urandom), ra, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                 $urandom % 3, $urandom % 3, got);
    end

    // Reset in the middle of beat1 of a split store
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h0000_2002; req_size = 2'd2; req_wdata = 32'h5566_7788;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus_valid && cyc < 10);
    chk("t6_beat0_seen", {31'h0, bus_valid}, 32'h1);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    chk("t6_beat1_addr", bus_addr, 32'h0000_2004);
    rst_n = 1'b0;
    #1;
    chk("t6_bus_valid_drop", {31'h0, bus_valid}, 32'h0);
    chk("t6_req_ready", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    rst_n = 1'b1;
    run_access(1'b1, 32'h0000_3001, 2'd0, 1'b0, 32'h0000_005A, 32'h0, 32'h0, 0, 0, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
